// File: rtl/f_absorb.sv
// f_absorb: multi-block absorb sequencer.
// Streams input blocks through an external mix unit and an external
// permutation unit, chaining the capacity state from block to block.
// The first block of a message loads c_init and x. Non-last blocks use
// `rounds` and the last block uses `rounds_final`. The final state and
// rate word are presented on a valid/ready output port.
// Optional feature: define F_ABSORB_TIMEOUT_EN to enable a watchdog.
// With the watchdog, a MIX or PERM wait of TIMEOUT cycles without the
// matching done moves the block into a sticky ERR state.
module f_absorb #(
  parameter int CWIDTH      = 320,
  parameter int XWORDS32    = 9,
  parameter int IWIDTH      = 128,
  parameter int DS_WIDTH    = 4,
  parameter int RWIDTH      = 32,
  parameter int ROUND_COUNT = 10,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CWIDTH-1:0]        c_init,
  input  logic [XWORDS32*32-1:0]   x,
  input  logic [ROUND_COUNT-1:0]   rounds,
  input  logic [ROUND_COUNT-1:0]   rounds_final,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IWIDTH-1:0]        in_i,
  input  logic [DS_WIDTH-1:0]      in_ds,
  input  logic                     in_last,
  output logic                     mix_start,
  output logic [CWIDTH-1:0]        mix_c,
  output logic [IWIDTH-1:0]        mix_i,
  output logic [XWORDS32*32-1:0]   mix_x,
  output logic [DS_WIDTH-1:0]      mix_ds,
  input  logic                     mix_done,
  input  logic [CWIDTH-1:0]        mix_cout,
  output logic                     perm_start,
  output logic [CWIDTH-1:0]        perm_c,
  output logic [ROUND_COUNT-1:0]   perm_rounds,
  input  logic                     perm_done,
  input  logic [CWIDTH-1:0]        perm_cout,
  input  logic [RWIDTH-1:0]        perm_rout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CWIDTH-1:0]        cout,
  output logic [RWIDTH-1:0]        rout,
  output logic [CNT_WIDTH-1:0]     blk_cnt,
  output logic                     busy,
  output logic                     err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MIX,
    S_PERM,
    S_OUT,
    S_ERR
  } state_e;

  state_e                   fsm_q;
  logic                     first_q;
  logic [CWIDTH-1:0]        st_q;
  logic [XWORDS32*32-1:0]   x_q;
  logic [IWIDTH-1:0]        in_q;
  logic [DS_WIDTH-1:0]      ds_q;
  logic                     last_q;
  logic [ROUND_COUNT-1:0]   perm_rounds_q;
  logic [RWIDTH-1:0]        rout_q;
  logic [CNT_WIDTH-1:0]     blk_cnt_q;
  logic                     mix_start_q;
  logic                     perm_start_q;

  logic [CNT_WIDTH-1:0]     blk_cnt_d;
  logic [ROUND_COUNT-1:0]   perm_rounds_d;

`ifdef F_ABSORB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  logic [TW-1:0]            timer_q;
  logic                     err_q;
`endif

  // Block counter saturates at all-ones instead of wrapping.
  assign blk_cnt_d     = (&blk_cnt_q) ? blk_cnt_q : blk_cnt_q + 1'b1;
  assign perm_rounds_d = last_q ? rounds_final : rounds;

  // Main sequencer: state, operand registers and start pulses.
  always_ff @(posedge clk) begin
    // NOTE: the whole datapath is cleared on reset, not just the control bits, so operand and result ports read 0 after reset.
    if (reset) begin
      fsm_q         <= S_IDLE;
      first_q       <= 1'b1;
      st_q          <= '0;
      x_q           <= '0;
      in_q          <= '0;
      ds_q          <= '0;
      last_q        <= 1'b0;
      perm_rounds_q <= '0;
      rout_q        <= '0;
      blk_cnt_q     <= '0;
      mix_start_q   <= 1'b0;
      perm_start_q  <= 1'b0;
`ifdef F_ABSORB_TIMEOUT_EN
      timer_q       <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register see only pre-edge values. The default clears below turn the start strobes into one-cycle pulses.
      mix_start_q  <= 1'b0;
      perm_start_q <= 1'b0;
      unique case (fsm_q)
        S_IDLE: begin
          if (in_valid) begin
            in_q   <= in_i;
            ds_q   <= in_ds;
            last_q <= in_last;
            if (first_q) begin
              st_q      <= c_init;
              x_q       <= x;
              blk_cnt_q <= '0;
              first_q   <= 1'b0;
            end
            mix_start_q <= 1'b1;
            fsm_q       <= S_MIX;
`ifdef F_ABSORB_TIMEOUT_EN
            timer_q     <= '0;
`endif
          end
        end
        S_MIX: begin
          if (mix_done) begin
            st_q          <= mix_cout;
            perm_rounds_q <= perm_rounds_d;
            perm_start_q  <= 1'b1;
            fsm_q         <= S_PERM;
`ifdef F_ABSORB_TIMEOUT_EN
            timer_q       <= '0;
          end else if (timer_q == TIMER_MAX) begin
            err_q <= 1'b1;
            fsm_q <= S_ERR;
          end else begin
            timer_q <= timer_q + 1'b1;
`endif
          end
        end
        S_PERM: begin
          if (perm_done) begin
            st_q      <= perm_cout;
            rout_q    <= perm_rout;
            blk_cnt_q <= blk_cnt_d;
            fsm_q     <= last_q ? S_OUT : S_IDLE;
`ifdef F_ABSORB_TIMEOUT_EN
          end else if (timer_q == TIMER_MAX) begin
            err_q <= 1'b1;
            fsm_q <= S_ERR;
          end else begin
            timer_q <= timer_q + 1'b1;
`endif
          end
        end
        S_OUT: begin
          if (out_ready) begin
            first_q <= 1'b1;
            fsm_q   <= S_IDLE;
          end
        end
        S_ERR: begin
          fsm_q <= S_ERR;
        end
        default: begin
          fsm_q <= S_IDLE;
        end
      endcase
    end
  end

  // The operand ports read the registers directly. These registers change
  // only on the done that ends each phase, so the operands stay stable.
  assign mix_start   = mix_start_q;
  assign mix_c       = st_q;
  assign mix_i       = in_q;
  assign mix_x       = x_q;
  assign mix_ds      = ds_q;
  assign perm_start  = perm_start_q;
  assign perm_c      = st_q;
  assign perm_rounds = perm_rounds_q;

  // Handshake and status flags are decoded from the state register only.
  assign in_ready  = (fsm_q == S_IDLE);
  assign out_valid = (fsm_q == S_OUT);
  assign busy      = (fsm_q != S_IDLE);
  assign cout      = st_q;
  assign rout      = rout_q;
  assign blk_cnt   = blk_cnt_q;

`ifdef F_ABSORB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_f_absorb.sv
// tb_f_absorb: directed and randomized bench for f_absorb.
// The mix unit is modelled as c ^ i with a selectable latency. The
// permutation unit is modelled as c + rounds with a selectable latency.
// Expected results come from folding each message over those rules.
module tb_f_absorb;
  localparam int CW  = 320;
  localparam int XW  = 9 * 32;
  localparam int IW  = 128;
  localparam int DW  = 4;
  localparam int RW  = 32;
  localparam int RC  = 10;
  localparam int NW  = 16;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] c_init = '0;
  logic [XW-1:0] x = '0;
  logic [RC-1:0] rounds = '0;
  logic [RC-1:0] rounds_final = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_i = '0;
  logic [DW-1:0] in_ds = '0;
  logic          in_last = 1'b0;
  logic          mix_start;
  logic [CW-1:0] mix_c;
  logic [IW-1:0] mix_i;
  logic [XW-1:0] mix_x;
  logic [DW-1:0] mix_ds;
  logic          mix_done;
  logic [CW-1:0] mix_cout;
  logic          perm_start;
  logic [CW-1:0] perm_c;
  logic [RC-1:0] perm_rounds;
  logic          perm_done;
  logic [CW-1:0] perm_cout;
  logic [RW-1:0] perm_rout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] cout;
  logic [RW-1:0] rout;
  logic [NW-1:0] blk_cnt;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Environment models
  int            mix_lat = 2;
  int            perm_lat = 3;
  int            gap_max = 0;
  bit            perm_hang = 1'b0;
  int            mix_cnt = -1;
  int            perm_cnt = -1;
  logic [CW-1:0] mix_res = '0;
  logic [CW-1:0] perm_res = '0;
  logic          mix_done_m = 1'b0;
  logic          perm_done_m = 1'b0;
  logic [CW-1:0] mix_cout_m = '0;
  logic [CW-1:0] perm_cout_m = '0;
  logic          spur_mix = 1'b0;
  logic          spur_perm = 1'b0;
  logic [CW-1:0] spur_val = '0;
  logic [RC-1:0] rounds_seen[$];
  logic [IW-1:0] msg_q[$];
  logic [CW-1:0] exp_s = '0;
  int            exp_n = 0;

  assign mix_done  = mix_done_m | spur_mix;
  assign mix_cout  = spur_mix ? spur_val : mix_cout_m;
  assign perm_done = perm_done_m | spur_perm;
  assign perm_cout = spur_perm ? spur_val : perm_cout_m;
  assign perm_rout = spur_perm ? spur_val[RW-1:0] : perm_cout_m[RW-1:0];

  f_absorb #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .c_init(c_init), .x(x),
    .rounds(rounds), .rounds_final(rounds_final),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_ds(in_ds), .in_last(in_last),
    .mix_start(mix_start), .mix_c(mix_c), .mix_i(mix_i), .mix_x(mix_x), .mix_ds(mix_ds),
    .mix_done(mix_done), .mix_cout(mix_cout),
    .perm_start(perm_start), .perm_c(perm_c), .perm_rounds(perm_rounds),
    .perm_done(perm_done), .perm_cout(perm_cout), .perm_rout(perm_rout),
    .out_valid(out_valid), .out_ready(out_ready), .cout(cout), .rout(rout),
    .blk_cnt(blk_cnt), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mix unit model: the done pulse arrives mix_lat cycles after the start cycle.
  always @(negedge clk) begin
    if (mix_start && mix_lat == 0) begin
      mix_done_m <= 1'b1;
      mix_cout_m <= mix_c ^ CW'(mix_i);
      mix_cnt    <= -1;
    end else if (mix_start) begin
      mix_done_m <= 1'b0;
      mix_res    <= mix_c ^ CW'(mix_i);
      mix_cnt    <= mix_lat - 1;
    end else if (mix_cnt == 0) begin
      mix_done_m <= 1'b1;
      mix_cout_m <= mix_res;
      mix_cnt    <= -1;
    end else begin
      mix_done_m <= 1'b0;
      if (mix_cnt > 0) mix_cnt <= mix_cnt - 1;
    end
  end

  // Permutation unit model: the done pulse arrives perm_lat cycles after start.
  // The model never answers while perm_hang is set.
  always @(negedge clk) begin
    if (perm_start) rounds_seen.push_back(perm_rounds);
    if (perm_start && !perm_hang && perm_lat == 0) begin
      perm_done_m <= 1'b1;
      perm_cout_m <= perm_c + CW'(perm_rounds);
      perm_cnt    <= -1;
    end else if (perm_start && !perm_hang) begin
      perm_done_m <= 1'b0;
      perm_res    <= perm_c + CW'(perm_rounds);
      perm_cnt    <= perm_lat - 1;
    end else if (perm_cnt == 0) begin
      perm_done_m <= 1'b1;
      perm_cout_m <= perm_res;
      perm_cnt    <= -1;
    end else begin
      perm_done_m <= 1'b0;
      if (perm_cnt > 0) perm_cnt <= perm_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] rand_bits();
    logic [CW-1:0] v;
    for (int i = 0; i < CW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Present one block and hold it until it is accepted.
  // acc_cyc is the index of the accepting edge.
  task automatic send_block(input logic [IW-1:0] d, input logic [DW-1:0] ds,
                            input bit last, output int acc_cyc);
    int n;
    repeat ($urandom_range(0, gap_max)) tick();
    in_i = d; in_ds = ds; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 500) begin tick(); n++; end
    check("in_ready_before_accept", in_ready, 1'b1);
    tick();
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_i = IW'(rand_bits());
    in_ds = DW'($urandom);
    check("mix_start_pulse", mix_start, 1'b1);
  endtask

  // Send the whole message in msg_q and check every block and the result.
  task automatic run_msg(input logic [CW-1:0] c0, input logic [XW-1:0] xv,
                         input logic [RC-1:0] r, input logic [RC-1:0] rf, input int hold);
    logic [CW-1:0] s;
    logic [DW-1:0] ds;
    bit            last;
    int            acc;
    int            n;
    c_init = c0; x = xv; rounds = r; rounds_final = rf;
    rounds_seen.delete();
    s = c0;
    for (int k = 0; k < msg_q.size(); k++) begin
      last = (k == msg_q.size() - 1);
      ds = DW'($urandom);
      send_block(msg_q[k], ds, last, acc);
      check("mix_c", mix_c, s);
      check("mix_i", mix_i, msg_q[k]);
      check("mix_x", mix_x, xv);
      check("mix_ds", mix_ds, ds);
      // c_init and x only matter for the first block of a message.
      c_init = rand_bits();
      x = XW'(rand_bits());
      s = (s ^ CW'(msg_q[k])) + CW'(last ? rf : r);
      n = 0;
      if (last) begin
        while (!out_valid && n < 200) begin tick(); n++; end
        check("out_valid_rise", out_valid, 1'b1);
      end else begin
        while (!in_ready && n < 200) begin tick(); n++; end
        check("in_ready_return", in_ready, 1'b1);
      end
      check("block_latency", cyc - acc, 2 + mix_lat + perm_lat);
      check("blk_cnt", blk_cnt, k + 1);
    end
    check("cout", cout, s);
    check("rout", rout, s[RW-1:0]);
    check("busy_in_out", busy, 1'b1);
    check("in_ready_in_out", in_ready, 1'b0);
    check("rounds_seen_len", rounds_seen.size(), msg_q.size());
    for (int k = 0; k < rounds_seen.size() && k < msg_q.size(); k++)
      check("perm_rounds", rounds_seen[k], (k == msg_q.size() - 1) ? rf : r);
    exp_s = s;
    exp_n = msg_q.size();
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin spur_mix = 1'b1; spur_val = rand_bits(); end
      if (h == 2) begin spur_perm = 1'b1; spur_val = rand_bits(); end
      tick();
      spur_mix = 1'b0; spur_perm = 1'b0;
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_cout", cout, s);
      check("hold_rout", rout, s[RW-1:0]);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_blk_cnt", blk_cnt, exp_n);
      check("hold_no_perm_start", perm_start, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_after_out", in_ready, 1'b1);
    check("busy_after_out", busy, 1'b0);
  endtask

  initial begin
    int acc;
    int n;
    int s_cyc;
    int nb;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_mix_start", mix_start, 1'b0);
    check("rst_perm_start", perm_start, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_cout", cout, 0);
    check("rst_rout", rout, 0);
    check("rst_mix_c", mix_c, 0);
    check("rst_mix_i", mix_i, 0);
    check("rst_mix_x", mix_x, 0);
    check("rst_mix_ds", mix_ds, 0);
    check("rst_perm_c", perm_c, 0);
    check("rst_perm_rounds", perm_rounds, 0);
    reset = 1'b0;
    tick();

    // Single block with the default model latencies
    mix_lat = 2; perm_lat = 3;
    msg_q = '{128'd5};
    run_msg('0, XW'(rand_bits()), 10'd10, 10'd12, 0);

    // Three blocks chained through the capacity state
    msg_q = '{128'd1, 128'd2, 128'd4};
    run_msg('0, XW'(rand_bits()), 10'd10, 10'd12, 0);

    // Output back-pressure, then a new message from a fresh c_init
    msg_q = '{IW'(rand_bits()), IW'(rand_bits())};
    run_msg(rand_bits(), XW'(rand_bits()), 10'd7, 10'd3, 5);
    msg_q = '{IW'(rand_bits())};
    run_msg(rand_bits(), XW'(rand_bits()), 10'd1, 10'd20, 0);

    // Spurious done pulses while idle
    spur_mix = 1'b1; spur_val = rand_bits();
    tick();
    spur_mix = 1'b0; spur_perm = 1'b1; spur_val = rand_bits();
    tick();
    spur_perm = 1'b0;
    tick();
    check("idle_spur_busy", busy, 1'b0);
    check("idle_spur_in_ready", in_ready, 1'b1);
    check("idle_spur_mix_start", mix_start, 1'b0);
    check("idle_spur_blk_cnt", blk_cnt, exp_n);
    check("idle_spur_cout", cout, exp_s);
    check("idle_spur_rout", rout, exp_s[RW-1:0]);

    // Reset in the middle of the PERM phase of block 2
    c_init = rand_bits(); x = XW'(rand_bits()); rounds = 10'd9; rounds_final = 10'd4;
    send_block(IW'(rand_bits()), 4'h1, 1'b0, acc);
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    check("mid_blk1_done", in_ready, 1'b1);
    check("mid_blk1_cnt", blk_cnt, 1);
    send_block(IW'(rand_bits()), 4'h2, 1'b0, acc);
    n = 0;
    while (!perm_start && n < 200) begin tick(); n++; end
    check("mid_perm_start", perm_start, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_blk_cnt", blk_cnt, 0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_cout", cout, 0);
    repeat (6) tick();
    check("late_done_busy", busy, 1'b0);
    check("late_done_in_ready", in_ready, 1'b1);
    check("late_done_blk_cnt", blk_cnt, 0);
    check("late_done_cout", cout, 0);
    check("late_done_rout", rout, 0);
    msg_q = '{IW'(rand_bits()), IW'(rand_bits())};
    run_msg(rand_bits(), XW'(rand_bits()), 10'd5, 10'd6, 0);

    // Randomized messages with random latencies, input gaps and back-pressure
    gap_max = 2;
    for (int m = 0; m < 8; m++) begin
      mix_lat = $urandom_range(0, 3);
      perm_lat = $urandom_range(1, 4);
      nb = $urandom_range(1, 4);
      msg_q.delete();
      for (int b = 0; b < nb; b++) msg_q.push_back(IW'(rand_bits()));
      run_msg(rand_bits(), XW'(rand_bits()), RC'($urandom), RC'($urandom), $urandom_range(0, 3));
    end
    gap_max = 0;

`ifdef F_ABSORB_TIMEOUT_EN
    // Watchdog: the permutation unit never answers
    mix_lat = 2; perm_lat = 3; perm_hang = 1'b1;
    c_init = rand_bits(); rounds_final = 10'd2;
    send_block(IW'(rand_bits()), 4'h3, 1'b1, acc);
    n = 0;
    while (!perm_start && n < 200) begin tick(); n++; end
    check("tmo_perm_start", perm_start, 1'b1);
    s_cyc = cyc;
    repeat (TMO - 1) tick();
    check("tmo_err_early", err, 1'b0);
    tick();
    check("tmo_err_set", err, 1'b1);
    check("tmo_err_delay", cyc - s_cyc, TMO);
    check("tmo_in_ready", in_ready, 1'b0);
    check("tmo_out_valid", out_valid, 1'b0);
    repeat (5) tick();
    check("tmo_err_sticky", err, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    perm_hang = 1'b0;
    check("tmo_err_cleared", err, 1'b0);
    check("tmo_in_ready_after_rst", in_ready, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound on the run
  initial begin
    #600000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "run did not finish");
  end

endmodule
